// File: rtl/pe_pass_scheduler.sv
// pe_pass_scheduler: sequences a brick-fused PE over 1..4 passes per job.
// Optional saturating accumulate: define PE_SCHED_SAT_EN.
module pe_pass_scheduler #(
    parameter int PROD_W   = 19,
    parameter int ACC_W    = 24,
    parameter int MAX_PASS = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [2:0]        i_num_pass,
    input  logic [15:0]       i_shift_tab,
    input  logic [3:0]        i_a_sgn_mask,
    input  logic [3:0]        i_w_sgn_mask,
    input  logic              i_op_valid,
    output logic              o_op_ready,
    input  logic [31:0]       i_op_act,
    input  logic [31:0]       i_op_wgt,
    output logic [31:0]       o_pe_act,
    output logic [31:0]       o_pe_wgt,
    output logic              o_pe_A_signed,
    output logic              o_pe_W_signed,
    output logic [3:0]        o_pe_shift,
    input  logic [PROD_W-1:0] i_pe_prod,
    output logic              o_res_valid,
    input  logic              i_res_ready,
    output logic [ACC_W-1:0]  o_res_data,
    output logic              o_res_sat,
    output logic              o_busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                   state;
    logic [2:0]               num_pass_q;
    logic [15:0]              shift_tab_q;
    logic [3:0]               a_mask_q;
    logic [3:0]               w_mask_q;
    logic [1:0]               pass_cnt;
    logic                     pending;
    logic signed [ACC_W-1:0]  acc;
    logic                     sat_q;
    logic                     op_ready_q;
    logic                     res_valid_q;
    logic                     busy_q;

    logic                     hs;
    logic                     last_pass;
    logic                     start_ok;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  acc_nxt;
    logic                     clamp;

    assign hs        = (state == S_ISSUE) & i_op_valid & op_ready_q;
    assign last_pass = ({1'b0, pass_cnt} == (num_pass_q - 3'd1));
    assign start_ok  = i_start & (i_num_pass != 3'd0)
                     & (i_num_pass <= 3'(MAX_PASS));
    assign prod_ext  = ACC_W'($signed(i_pe_prod));

    // PE drive: operands and per-pass controls only on a handshake
    assign o_pe_act      = hs ? i_op_act : 32'd0;
    assign o_pe_wgt      = hs ? i_op_wgt : 32'd0;
    assign o_pe_shift    = hs ? shift_tab_q[{pass_cnt, 2'b00} +: 4] : 4'd0;
    assign o_pe_A_signed = hs & a_mask_q[pass_cnt];
    assign o_pe_W_signed = hs & w_mask_q[pass_cnt];

`ifdef PE_SCHED_SAT_EN
    logic [ACC_W:0] sum_wide;

    // Widened add, clamp to the signed range on overflow
    always_comb begin
        sum_wide = {acc[ACC_W-1], acc} + {prod_ext[ACC_W-1], prod_ext};
        clamp    = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
        acc_nxt  = sum_wide[ACC_W-1:0];
        if (clamp) begin
            acc_nxt = sum_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                      : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end
`else
    assign acc_nxt = acc + prod_ext;
    assign clamp   = 1'b0;
`endif

    assign o_op_ready  = op_ready_q;
    assign o_res_valid = res_valid_q;
    assign o_res_data  = res_valid_q ? acc : '0;
    assign o_res_sat   = res_valid_q & sat_q;
    assign o_busy      = busy_q;

    // Job FSM, pass counting and product accumulation
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= S_IDLE;
            num_pass_q  <= 3'd0;
            shift_tab_q <= 16'd0;
            a_mask_q    <= 4'd0;
            w_mask_q    <= 4'd0;
            pass_cnt    <= 2'd0;
            pending     <= 1'b0;
            acc         <= '0;
            sat_q       <= 1'b0;
            op_ready_q  <= 1'b0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            pending <= hs;
            if (pending) begin
                acc   <= acc_nxt;
                sat_q <= sat_q | clamp;
            end
            case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        num_pass_q  <= i_num_pass;
                        shift_tab_q <= i_shift_tab;
                        a_mask_q    <= i_a_sgn_mask;
                        w_mask_q    <= i_w_sgn_mask;
                        pass_cnt    <= 2'd0;
                        acc         <= '0;
                        sat_q       <= 1'b0;
                        op_ready_q  <= 1'b1;
                        busy_q      <= 1'b1;
                        state       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (hs) begin
                        pass_cnt <= pass_cnt + 2'd1;
                        if (last_pass) begin
                            op_ready_q <= 1'b0;
                            state      <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    res_valid_q <= 1'b1;
                    state       <= S_DONE;
                end
                S_DONE: begin
                    if (i_res_ready) begin
                        res_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pe_pass_scheduler.sv
// tb_pe_pass_scheduler: scheduler driving a behavioural 16 x 2b brick PE.
// Expected results depend on PE_SCHED_SAT_EN for the overflow vector.
module tb_pe_pass_scheduler;

    localparam int PW = 19;
    localparam int AW = 19;

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          i_start = 1'b0;
    logic [2:0]    i_num_pass = '0;
    logic [15:0]   i_shift_tab = '0;
    logic [3:0]    i_a_sgn_mask = '0;
    logic [3:0]    i_w_sgn_mask = '0;
    logic          i_op_valid = 1'b0;
    logic          o_op_ready;
    logic [31:0]   i_op_act = '0;
    logic [31:0]   i_op_wgt = '0;
    logic [31:0]   o_pe_act;
    logic [31:0]   o_pe_wgt;
    logic          o_pe_A_signed;
    logic          o_pe_W_signed;
    logic [3:0]    o_pe_shift;
    logic [PW-1:0] i_pe_prod;
    logic          o_res_valid;
    logic          i_res_ready = 1'b0;
    logic [AW-1:0] o_res_data;
    logic          o_res_sat;
    logic          o_busy;

    pe_pass_scheduler #(.PROD_W(PW), .ACC_W(AW), .MAX_PASS(4)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start),
        .i_num_pass(i_num_pass), .i_shift_tab(i_shift_tab),
        .i_a_sgn_mask(i_a_sgn_mask), .i_w_sgn_mask(i_w_sgn_mask),
        .i_op_valid(i_op_valid), .o_op_ready(o_op_ready),
        .i_op_act(i_op_act), .i_op_wgt(i_op_wgt),
        .o_pe_act(o_pe_act), .o_pe_wgt(o_pe_wgt),
        .o_pe_A_signed(o_pe_A_signed), .o_pe_W_signed(o_pe_W_signed),
        .o_pe_shift(o_pe_shift), .i_pe_prod(i_pe_prod),
        .o_res_valid(o_res_valid), .i_res_ready(i_res_ready),
        .o_res_data(o_res_data), .o_res_sat(o_res_sat), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc++;

    // Behavioural PE: brick dot product, shifted, one-cycle registered
    function automatic logic [PW-1:0] pe_fn(
        input logic [31:0] a, input logic [31:0] w,
        input logic as, input logic ws, input logic [3:0] sh);
        int s;
        int k;
        int av;
        int wv;
        logic [1:0] ab;
        logic [1:0] wb;
        s = 0;
        for (int i = 0; i < 16; i++) begin
            ab = a[2*i +: 2];
            wb = w[2*i +: 2];
            av = (as && ab[1]) ? int'(ab) - 4 : int'(ab);
            wv = (ws && wb[1]) ? int'(wb) - 4 : int'(wb);
            s += av * wv;
        end
        k = (sh == 4'd2 || sh == 4'd6 || sh == 4'd10) ? int'(sh) : 0;
        return PW'(s * (1 << k));
    endfunction

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) i_pe_prod <= '0;
        else i_pe_prod <= pe_fn(o_pe_act, o_pe_wgt,
                                o_pe_A_signed, o_pe_W_signed, o_pe_shift);
    end

    typedef struct {
        logic [2:0]        np;
        logic [15:0]       tab;
        logic [3:0]        am;
        logic [3:0]        wm;
        logic [3:0][31:0]  act;
        logic [3:0][31:0]  wgt;
        int                bub;
        logic [AW-1:0]     exp_d;
        logic              exp_s;
    } vec_t;

    typedef struct packed {
        logic [AW-1:0] d;
        logic          s;
    } res_t;

    vec_t tbl[8];
    res_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Start a job, feed its passes, wait for and check the result
    task automatic run_job(input vec_t v, input bit accept);
        int t0;
        res_t r;
        i_num_pass   = v.np;
        i_shift_tab  = v.tab;
        i_a_sgn_mask = v.am;
        i_w_sgn_mask = v.wm;
        i_start      = 1'b1;
        sb.push_back('{d: v.exp_d, s: v.exp_s});
        t0 = cyc;
        step();
        i_start = 1'b0;
        chk("busy_on_start", o_busy, 1);
        for (int p = 0; p < int'(v.np); p++) begin
            if (p > 0) begin
                for (int b = 0; b < v.bub; b++) begin
                    i_op_valid = 1'b0;
                    #1;
                    chk("bubble_pe_act", o_pe_act, 0);
                    step();
                end
            end
            i_op_valid = 1'b1;
            i_op_act   = v.act[p];
            i_op_wgt   = v.wgt[p];
            #1;
            chk("op_ready", o_op_ready, 1);
            chk("pe_act", o_pe_act, v.act[p]);
            chk("pe_wgt", o_pe_wgt, v.wgt[p]);
            chk("pe_shift", o_pe_shift, v.tab[4*p +: 4]);
            chk("pe_a_signed", o_pe_A_signed, v.am[p]);
            chk("pe_w_signed", o_pe_W_signed, v.wm[p]);
            step();
        end
        i_op_valid = 1'b0;
        i_op_act   = '0;
        i_op_wgt   = '0;
        for (int w = 0; w < 20 && !o_res_valid; w++) step();
        chk("res_valid_seen", o_res_valid, 1);
        chk("latency", cyc - t0,
            int'(v.np) + 2 + v.bub * (int'(v.np) - 1));
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 0, 1);
        end else begin
            r = sb.pop_front();
            chk("res_data", o_res_data, r.d);
            chk("res_sat", o_res_sat, r.s);
        end
        if (accept) begin
            i_res_ready = 1'b1;
            step();
            i_res_ready = 1'b0;
            chk("busy_after_accept", o_busy, 0);
            chk("valid_after_accept", o_res_valid, 0);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec_t v;
        tbl[0] = '{np: 3'd4, tab: 16'hA620, am: 4'h0, wm: 4'h0,
                   act: {4{32'h1}}, wgt: {4{32'h1}}, bub: 0,
                   exp_d: 19'd1093, exp_s: 1'b0};
        tbl[1] = tbl[0];
        tbl[1].bub = 3;
        tbl[2] = '{np: 3'd1, tab: 16'h0000, am: 4'h1, wm: 4'h1,
                   act: {96'h0, 32'h3}, wgt: {96'h0, 32'h1}, bub: 0,
                   exp_d: 19'h7FFFF, exp_s: 1'b0};
        tbl[3] = '{np: 3'd2, tab: 16'h0020, am: 4'h0, wm: 4'h0,
                   act: {64'h0, 32'h1, 32'hFFFF_FFFF},
                   wgt: {64'h0, 32'h3, 32'hFFFF_FFFF}, bub: 0,
                   exp_d: 19'd156, exp_s: 1'b0};
        tbl[4] = '{np: 3'd1, tab: 16'h0005, am: 4'h0, wm: 4'h0,
                   act: {4{32'h1}}, wgt: {4{32'h1}}, bub: 0,
                   exp_d: 19'd1, exp_s: 1'b0};
        tbl[5] = '{np: 3'd1, tab: 16'h0006, am: 4'h1, wm: 4'h1,
                   act: {4{32'hAAAA_AAAA}}, wgt: {4{32'hAAAA_AAAA}},
                   bub: 0, exp_d: 19'd4096, exp_s: 1'b0};
        tbl[6] = '{np: 3'd3, tab: 16'h0620, am: 4'h1, wm: 4'h4,
                   act: {32'h0, 32'h1, 32'h5, 32'h2},
                   wgt: {32'h0, 32'h3, 32'h7, 32'h3}, bub: 2,
                   exp_d: 19'h7FFCA, exp_s: 1'b0};
`ifdef PE_SCHED_SAT_EN
        tbl[7] = '{np: 3'd4, tab: 16'hAAAA, am: 4'h0, wm: 4'h0,
                   act: {4{32'hFFFF_FFFF}}, wgt: {4{32'hFFFF_FFFF}},
                   bub: 1, exp_d: 19'd262143, exp_s: 1'b1};
`else
        tbl[7] = '{np: 3'd4, tab: 16'hAAAA, am: 4'h0, wm: 4'h0,
                   act: {4{32'hFFFF_FFFF}}, wgt: {4{32'hFFFF_FFFF}},
                   bub: 1, exp_d: 19'd65536, exp_s: 1'b0};
`endif

        #23;
        chk("rst_busy", o_busy, 0);
        chk("rst_ready", o_op_ready, 0);
        chk("rst_valid", o_res_valid, 0);
        chk("rst_data", o_res_data, 0);
        chk("rst_pe_act", o_pe_act, 0);
        step();
        i_rst_n = 1'b1;
        step();

        for (int i = 0; i < 8; i++) begin
            run_job(tbl[i], 1'b1);
            step();
        end

        // Result held in DONE while the collector stalls; start ignored
        run_job(tbl[0], 1'b0);
        i_num_pass = 3'd1;
        for (int k = 0; k < 5; k++) begin
            i_start = (k == 2);
            step();
            chk("hold_valid", o_res_valid, 1);
            chk("hold_data", o_res_data, 19'd1093);
            chk("hold_busy", o_busy, 1);
        end
        i_res_ready = 1'b1;
        i_start     = 1'b1;
        step();
        i_res_ready = 1'b0;
        i_start     = 1'b0;
        chk("accept_busy", o_busy, 0);
        chk("accept_valid", o_res_valid, 0);
        step();
        chk("start_in_done_ignored", o_busy, 0);

        // Async reset after two handshakes of a four-pass job
        i_num_pass   = 3'd4;
        i_shift_tab  = 16'hA620;
        i_a_sgn_mask = 4'h0;
        i_w_sgn_mask = 4'h0;
        i_start      = 1'b1;
        step();
        i_start    = 1'b0;
        i_op_valid = 1'b1;
        i_op_act   = 32'h1;
        i_op_wgt   = 32'h1;
        step();
        step();
        i_rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", o_busy, 0);
        chk("mid_rst_ready", o_op_ready, 0);
        chk("mid_rst_pe_act", o_pe_act, 0);
        chk("mid_rst_shift", o_pe_shift, 0);
        chk("mid_rst_valid", o_res_valid, 0);
        chk("mid_rst_data", o_res_data, 0);
        i_op_valid = 1'b0;
        step();
        i_rst_n = 1'b1;
        step();
        v = '{np: 3'd1, tab: 16'h0000, am: 4'h0, wm: 4'h0,
              act: {4{32'h1}}, wgt: {4{32'h1}}, bub: 0,
              exp_d: 19'd1, exp_s: 1'b0};
        run_job(v, 1'b1);
        step();

        // Illegal pass counts never start a job
        i_num_pass = 3'd0;
        i_start    = 1'b1;
        step();
        i_start = 1'b0;
        chk("np0_ignored", o_busy, 0);
        i_num_pass = 3'd5;
        i_start    = 1'b1;
        step();
        i_start = 1'b0;
        chk("np5_ignored", o_busy, 0);
        chk("sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
